// File: rtl/smg_scan_ctrl_module_if.sv
// Signal bundle between the number/BCD source, the scan controller and the segment encoder.
// The controller sits on the slave side; the source/encoder side uses master.
interface smg_scan_ctrl_module_if #(
  parameter int DIGITS = 6
);
  logic                  enable;
  logic                  lz_blank;
  logic [4*DIGITS-1:0]   number_sig;
  logic [DIGITS-1:0]     dp_sig;
  logic [3:0]            number_data;
  logic [DIGITS-1:0]     dig_sel;
  logic                  dp_out;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output enable, lz_blank, number_sig, dp_sig,
    input  number_data, dig_sel, dp_out, blank, frame_done
  );

  modport slave (
    input  enable, lz_blank, number_sig, dp_sig,
    output number_data, dig_sel, dp_out, blank, frame_done
  );
endinterface

// File: rtl/smg_scan_ctrl_module.sv
// Time-multiplexed seven-segment scan controller: per-frame input snapshot, blank guard
// at the start of each slot, optional leading-zero suppression and an end-of-frame pulse.
module smg_scan_ctrl_module #(
  parameter int DIGITS       = 6,
  parameter int CLK_DIV      = 49999,
  parameter int BLANK_CYCLES = 500
) (
  input logic                   clk,
  input logic                   rst,
  smg_scan_ctrl_module_if.slave bus
);

  localparam int CW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap;
  logic [DIGITS-1:0]   dp_snap;

  logic              tick;
  logic              load;
  logic              in_guard;
  logic [DIGITS-1:0] supp;
  logic              cur_supp;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [DIGITS-1:0] cur_sel;
  logic              blank_int;

  assign tick = bus.enable && (cnt == CNT_MAX);
  assign load = bus.enable && (idx == '0) && (cnt == '0);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CW-1:0] GUARD_END = CW'(BLANK_CYCLES);
      assign in_guard = (cnt < GUARD_END);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (!bus.enable) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  // The snapshot is taken only at a frame start so the display never tears mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      dp_snap <= '0;
    end else if (load) begin
      snap    <= bus.number_sig;
      dp_snap <= bus.dp_sig;
    end
  end

  // A zero run from the MS digit stays suppressible until a non-zero nibble or a set
  // decimal point breaks it; the LS digit always shows so a value of zero reads "0".
  always_comb begin : lz_scan
    logic run;
    run  = bus.lz_blank;
    supp = '0;
    for (int k = 0; k < DIGITS; k++) begin
      run     = run & (snap[4*(DIGITS-1-k) +: 4] == 4'h0) & ~dp_snap[DIGITS-1-k];
      supp[k] = run & (k != DIGITS - 1);
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    cur_sel  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib               = snap[4*(DIGITS-1-k) +: 4];
        cur_dp                = dp_snap[DIGITS-1-k];
        cur_supp              = supp[k];
        cur_sel[DIGITS-1-k]   = 1'b1;
      end
    end
  end

  assign blank_int = ~bus.enable | in_guard | cur_supp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.number_data <= '0;
      bus.dig_sel     <= '0;
      bus.dp_out      <= 1'b0;
      bus.blank       <= 1'b1;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.blank       <= blank_int;
      bus.dig_sel     <= blank_int ? '0 : cur_sel;
      bus.number_data <= blank_int ? 4'h0 : cur_nib;
      bus.dp_out      <= ~blank_int & cur_dp;
      bus.frame_done  <= tick && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_smg_scan_ctrl_module.sv
// Bench for smg_scan_ctrl_module: a 4-digit instance with a 2-cycle guard and a 1-digit
// instance with no guard, both checked every cycle against a slot/frame arithmetic model.
module tb_smg_scan_ctrl_module;

  localparam int S = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smg_scan_ctrl_module_if #(.DIGITS(4)) bus_a ();
  smg_scan_ctrl_module_if #(.DIGITS(1)) bus_b ();

  smg_scan_ctrl_module #(.DIGITS(4), .CLK_DIV(9), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  smg_scan_ctrl_module #(.DIGITS(1), .CLK_DIV(9), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int fd_a, fd_b;

  int          dig[2] = '{4, 1};
  int          bk[2]  = '{2, 0};
  int          pos[2];
  logic [31:0] msnap[2];
  logic [7:0]  mdp[2];
  logic [3:0]  e_data[2];
  logic [7:0]  e_sel[2];
  logic        e_dp[2];
  logic        e_blank[2];
  logic        e_fd[2];

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  vis;
    logic [3:0]  dp_vis;
  } vec_t;
  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_nib(input int u, input int k);
    return 4'(msnap[u] >> (4 * (dig[u] - 1 - k)));
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      pos[u] = 0; msnap[u] = '0; mdp[u] = '0;
      e_data[u] = '0; e_sel[u] = '0; e_dp[u] = 1'b0; e_blank[u] = 1'b1; e_fd[u] = 1'b0;
    end
  endtask

  // Output after an edge reflects the slot position and snapshot held before that edge.
  task automatic model_edge(input int u, input logic en, input logic lz,
                            input logic [31:0] num, input logic [7:0] dp);
    int  slot, off, first;
    logic hide;
    if (!en) begin
      e_data[u] = '0; e_sel[u] = '0; e_dp[u] = 1'b0; e_blank[u] = 1'b1; e_fd[u] = 1'b0;
      pos[u] = 0;
    end else begin
      slot  = pos[u] / S;
      off   = pos[u] % S;
      first = dig[u] - 1;
      for (int k = dig[u] - 1; k >= 0; k--)
        if (model_nib(u, k) != 4'h0 || mdp[u][dig[u]-1-k]) first = k;
      hide       = (off < bk[u]) || (lz && slot < first);
      e_blank[u] = hide;
      e_sel[u]   = hide ? 8'd0 : (8'd1 << (dig[u] - 1 - slot));
      e_data[u]  = hide ? 4'd0 : model_nib(u, slot);
      e_dp[u]    = !hide && mdp[u][dig[u]-1-slot];
      e_fd[u]    = (pos[u] == dig[u] * S - 1);
      if (pos[u] == 0) begin
        msnap[u] = num;
        mdp[u]   = dp;
      end
      pos[u] = (pos[u] + 1) % (dig[u] * S);
    end
  endtask

  task automatic compare_all();
    check_output("a.number_data", bus_a.number_data, e_data[0]);
    check_output("a.dig_sel", bus_a.dig_sel, e_sel[0]);
    check_output("a.dp_out", bus_a.dp_out, e_dp[0]);
    check_output("a.blank", bus_a.blank, e_blank[0]);
    check_output("a.frame_done", bus_a.frame_done, e_fd[0]);
    check_output("b.number_data", bus_b.number_data, e_data[1]);
    check_output("b.dig_sel", bus_b.dig_sel, e_sel[1]);
    check_output("b.dp_out", bus_b.dp_out, e_dp[1]);
    check_output("b.blank", bus_b.blank, e_blank[1]);
    check_output("b.frame_done", bus_b.frame_done, e_fd[1]);
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(0, bus_a.enable, bus_a.lz_blank, {16'b0, bus_a.number_sig}, {4'b0, bus_a.dp_sig});
      model_edge(1, bus_b.enable, bus_b.lz_blank, {28'b0, bus_b.number_sig}, {7'b0, bus_b.dp_sig});
    end
    #1;
    compare_all();
    if (bus_a.frame_done) fd_a++;
    if (bus_b.frame_done) fd_b++;
  endtask

  task automatic run(input int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic restart_a();
    bus_a.enable = 1'b0;
    apply_stimulus();
    bus_a.enable = 1'b1;
  endtask

  function automatic logic [15:0] rand_num();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    return v;
  endfunction

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    vecs[1] = '{16'h0040, 4'b0000, 1'b1, 4'b0011, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, 4'b0000};
    vecs[3] = '{16'h0005, 4'b0100, 1'b1, 4'b0111, 4'b0100};
    vecs[4] = '{16'h0040, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    vecs[5] = '{16'h9000, 4'b0000, 1'b1, 4'b1111, 4'b0000};
    vecs[6] = '{16'h0000, 4'b0001, 1'b1, 4'b0001, 4'b0001};
    vecs[7] = '{16'h00A0, 4'b1000, 1'b1, 4'b1111, 4'b1000};

    rst = 1'b1;
    bus_a.enable = 1'b0; bus_a.lz_blank = 1'b0; bus_a.number_sig = '0; bus_a.dp_sig = '0;
    bus_b.enable = 1'b0; bus_b.lz_blank = 1'b0; bus_b.number_sig = '0; bus_b.dp_sig = '0;
    model_reset();
    fd_a = 0; fd_b = 0;
    run(2);
    check_output("reset a.blank", bus_a.blank, 1);
    check_output("reset a.dig_sel", bus_a.dig_sel, 0);
    rst = 1'b0;

    // Basic scan: two frames of 1234 on the 4-digit unit, eight frames on the 1-digit one.
    bus_a.enable = 1'b1; bus_a.number_sig = 16'h1234;
    bus_b.enable = 1'b1; bus_b.number_sig = 4'h7;
    fd_a = 0; fd_b = 0;
    run(80);
    check_output("frame_done count a", fd_a, 2);
    check_output("frame_done count b", fd_b, 8);

    // Table-driven digit contents, sampled mid-slot.
    bus_b.lz_blank = 1'b1; bus_b.number_sig = 4'h0;
    foreach (vecs[i]) begin
      restart_a();
      bus_a.number_sig = vecs[i].num; bus_a.dp_sig = vecs[i].dp; bus_a.lz_blank = vecs[i].lz;
      for (int e = 0; e < 40; e++) begin
        apply_stimulus();
        if (e % 10 == 5) begin
          int  k;
          logic v;
          k = e / 10;
          v = vecs[i].vis[3-k];
          check_output($sformatf("vec%0d d%0d sel", i, k), bus_a.dig_sel, v ? (4'b1000 >> k) : 4'b0);
          check_output($sformatf("vec%0d d%0d data", i, k), bus_a.number_data, v ? vecs[i].num[4*(3-k) +: 4] : 4'h0);
          check_output($sformatf("vec%0d d%0d dp", i, k), bus_a.dp_out, v & vecs[i].dp_vis[3-k]);
          check_output($sformatf("vec%0d d%0d blank", i, k), bus_a.blank, !v);
          check_output("b lsd never hidden", bus_b.blank, 0);
        end
      end
    end

    // Mid-frame input change waits for the next frame.
    restart_a();
    bus_a.number_sig = 16'h1234; bus_a.dp_sig = '0; bus_a.lz_blank = 1'b0;
    for (int e = 0; e < 50; e++) begin
      apply_stimulus();
      if (e == 15) bus_a.number_sig = 16'h5678;
      if (e == 25) check_output("tear d2", bus_a.number_data, 4'h3);
      if (e == 35) check_output("tear d3", bus_a.number_data, 4'h4);
      if (e == 45) check_output("new frame d0", bus_a.number_data, 4'h5);
    end

    // Enable dropped mid-frame for 15 cycles.
    run(7);
    bus_a.enable = 1'b0;
    for (int e = 0; e < 15; e++) begin
      apply_stimulus();
      check_output("disabled blank", bus_a.blank, 1);
      check_output("disabled frame_done", bus_a.frame_done, 0);
    end
    bus_a.number_sig = 16'h9876;
    bus_a.enable = 1'b1;
    for (int e = 0; e < 13; e++) begin
      apply_stimulus();
      if (e == 5) begin
        check_output("reenable sel", bus_a.dig_sel, 4'b1000);
        check_output("reenable data", bus_a.number_data, 4'h9);
      end
    end

    // Asynchronous reset mid-slot.
    #3 rst = 1'b1;
    #1;
    check_output("async a.blank", bus_a.blank, 1);
    check_output("async a.dig_sel", bus_a.dig_sel, 0);
    check_output("async a.number_data", bus_a.number_data, 0);
    check_output("async b.blank", bus_b.blank, 1);
    check_output("async b.frame_done", bus_b.frame_done, 0);
    apply_stimulus();
    rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      apply_stimulus();
      if (e < 2) check_output("post-reset guard", bus_a.blank, 1);
      else check_output("post-reset first digit", bus_a.dig_sel, 4'b1000);
    end

    // Randomised traffic on both units.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 7) == 0)  bus_a.number_sig = rand_num();
      if ($urandom_range(0, 7) == 0)  bus_a.dp_sig = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 9) == 0)  bus_a.lz_blank = ~bus_a.lz_blank;
      if ($urandom_range(0, 39) == 0) bus_a.enable = 1'b0;
      else if ($urandom_range(0, 4) == 0) bus_a.enable = 1'b1;
      if ($urandom_range(0, 5) == 0)  bus_b.number_sig = 4'($urandom);
      if ($urandom_range(0, 5) == 0)  bus_b.dp_sig = 1'($urandom);
      if ($urandom_range(0, 9) == 0)  bus_b.lz_blank = ~bus_b.lz_blank;
      if ($urandom_range(0, 39) == 0) bus_b.enable = 1'b0;
      else if ($urandom_range(0, 4) == 0) bus_b.enable = 1'b1;
      apply_stimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
